rv_fetch_queue: RTL
===================

Name: rv_fetch_queue

Overview:
- Decoupled instruction fetch unit with a DEPTH-entry show-ahead prefetch FIFO.
- Issues pipelined requests to instruction memory, with up to MAX_OUTSTANDING in flight and in-order responses of any latency ≥1.
- Buffers returned instructions with their PCs and presents the FIFO head to decode.
- On a branch, redirects fetch, flushes the FIFO and silently discards all stale in-flight responses.

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered memory requests; ≥1.
- RESET_PC, 32'h0: first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- im_addr_o  out  32  fetch address; valid while im_rd_o=1.
- im_rd_o  out  1  fetch request.
- im_ready_i  in  1  memory accepts the request; a request is accepted when im_rd_o & im_ready_i.
- im_data_i  in  32  instruction word; valid with im_valid_i.
- im_valid_i  in  1  response for the oldest unanswered request; in order, earliest one cycle after acceptance.
- f_stall_i  in  1  decode not ready; head is not consumed.
- f_kill_i  in  1  discard the head entry.
- f_valid_o  out  1  FIFO non-empty.
- f_ir_o  out  32  head instruction.
- f_pc_o  out  32  head PC.
- f_pc_plus_4_o  out  32  head PC + 4.
- x_bra_i  in  1  branch/redirect.
- x_pc_bra_i  in  32  branch target.

Behaviour:

State:
- pc: next fetch address.
- FIFO of {ir, pc}, DEPTH entries, wrapping read/write pointers, count 0..DEPTH.
- inflight: 0..MAX_OUTSTANDING.
- drop: 0..MAX_OUTSTANDING; always drop ≤ inflight.

Reset (rst_n_i low, asynchronous):
- pc = RESET_PC; FIFO empty; inflight = 0; drop = 0.
- Outputs: f_valid_o=0, im_rd_o=0, f_ir_o=0, f_pc_o=0, f_pc_plus_4_o=0 (data outputs forced to 0 while empty).
- Reset asserted mid-operation abandons all state; responses arriving after release with inflight=0 are ignored.

Request issue (combinational):
- im_rd_o = !x_bra_i & (inflight < MAX_OUTSTANDING) & (count + (inflight − drop) < DEPTH).
- im_addr_o = pc.
- While im_rd_o=1 and im_ready_i=0: hold im_addr_o and im_rd_o stable until acceptance, unless x_bra_i fires.
- On acceptance: pc <= pc + 4 (32-bit wrap: 32'hFFFFFFFC → 0); inflight increments.

Response:
- im_valid_i with inflight=0 is a protocol error; ignore it.
- im_valid_i with drop>0: word discarded; drop and inflight decrement.
- Otherwise: push {im_data_i, pc of that request} into the FIFO; inflight decrements.
- The response PC comes from a request-PC shadow queue of MAX_OUTSTANDING entries.
- Space is guaranteed by the issue credit, so the FIFO never overflows.
- Simultaneous acceptance and response in one cycle: inflight unchanged.

Consume:
- Pop when f_valid_o & (f_kill_i | !f_stall_i).
- f_kill_i discards the head even if f_stall_i=1.
- Push and pop in the same cycle: count unchanged. Push while full is impossible.

Outputs:
- f_valid_o, f_ir_o, f_pc_o and f_pc_plus_4_o are driven from registered FIFO state only; no combinational path from im_*.
- Response-to-f_valid_o latency is 1 cycle.

Branch (x_bra_i=1, highest priority):
- Next cycle: pc = x_pc_bra_i; FIFO empty; no pop/push effect.
- drop = inflight minus (1 if a response arrives this cycle).
- inflight decrements if a response arrives. Any response arriving this cycle is discarded.
- No request is issued in the branch cycle; the first target request is issued the following cycle, giving a 1-cycle bubble minimum.
- Back-to-back branches: the last one wins.

Test Plan:
- Release reset, memory latency 1, im_ready_i=1, f_stall_i=0 → im_addr_o 0,4,8,… every cycle; f_valid_o high from cycle 3; f_pc_o/f_ir_o sequence matches; f_pc_plus_4_o = f_pc_o+4.
- f_stall_i=1 constantly, DEPTH=4 → exactly 4 requests accepted, then im_rd_o=0; count=4; release stall → head advances 1/cycle and fetch resumes.
- Memory latency 3, 3 requests in flight (0,4,8), x_bra_i with x_pc_bra_i=32'h100 → FIFO empties next cycle; the 3 responses are discarded; next f_pc_o is 32'h100, then 32'h104.
- im_ready_i low for 5 cycles → im_addr_o and im_rd_o stable throughout; exactly one acceptance when im_ready_i rises.
- f_kill_i=1 with f_stall_i=1 and head pc=8 → head popped; next head pc=12.
- Assert rst_n_i low between clock edges with the FIFO full → f_valid_o and im_rd_o drop immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv_fetch_queue_if.sv
// rv_fetch_queue_if: the instruction-memory request/response channel, the
// decode-facing FIFO head, and the branch redirect inputs of the fetch unit.
//   master : the fetch unit (drives im_addr_o/im_rd_o and the f_* head outputs)
//   slave  : the environment (memory, decode, execute)
`timescale 1ns/1ps
interface rv_fetch_queue_if;
    logic [31:0] im_addr_o;
    logic        im_rd_o;
    logic        im_ready_i;
    logic [31:0] im_data_i;
    logic        im_valid_i;
    logic        f_stall_i;
    logic        f_kill_i;
    logic        f_valid_o;
    logic [31:0] f_ir_o;
    logic [31:0] f_pc_o;
    logic [31:0] f_pc_plus_4_o;
    logic        x_bra_i;
    logic [31:0] x_pc_bra_i;

    modport master (
        output im_addr_o, im_rd_o, f_valid_o, f_ir_o, f_pc_o, f_pc_plus_4_o,
        input  im_ready_i, im_data_i, im_valid_i, f_stall_i, f_kill_i,
               x_bra_i, x_pc_bra_i
    );

    modport slave (
        input  im_addr_o, im_rd_o, f_valid_o, f_ir_o, f_pc_o, f_pc_plus_4_o,
        output im_ready_i, im_data_i, im_valid_i, f_stall_i, f_kill_i,
               x_bra_i, x_pc_bra_i
    );
endinterface

// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: decoupled instruction fetch unit with a DEPTH-entry
// show-ahead FIFO of {instruction, pc}.
//   clk_i   : clock, all state updates on the rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : rv_fetch_queue_if.master (memory request/response, decode head,
//             branch redirect)
// Requests are pipelined (up to MAX_OUTSTANDING in flight); responses come
// back in order. A branch flushes the FIFO and counts the stale in-flight
// responses so they are discarded on arrival.
`timescale 1ns/1ps
module rv_fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    rv_fetch_queue_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [SW-1:0] SH_LAST = SW'(MAX_OUTSTANDING - 1);

    // Shadow-queue pointer advance; MAX_OUTSTANDING need not be a power of two.
    function automatic logic [SW-1:0] sh_next(input logic [SW-1:0] p);
        if (p == SH_LAST) begin
            return {SW{1'b0}};
        end else begin
            return p + SW'(1'b1);
        end
    endfunction

    logic [31:0]   r_pc;
    logic [31:0]   r_fifo_ir [DEPTH];
    logic [31:0]   r_fifo_pc [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_inflight;
    logic [IW-1:0] r_drop;
    logic [31:0]   r_sh_pc [MAX_OUTSTANDING];
    logic [SW-1:0] r_sh_wptr;
    logic [SW-1:0] r_sh_rptr;

    logic [31:0] w_live;
    logic        w_rd;
    logic        w_accept;
    logic        w_resp;
    logic        w_push;
    logic        w_pop;

    // Issue credit, handshake qualifiers and FIFO push/pop decisions.
    always_comb begin
        // Live entries = buffered words plus in-flight requests that will not
        // be dropped; keeping this below DEPTH guarantees every response fits.
        w_live   = 32'(r_count) + 32'(r_inflight) - 32'(r_drop);
        w_rd     = rst_n_i & ~bus.x_bra_i
                 & (32'(r_inflight) < MAX_OUTSTANDING) & (w_live < DEPTH);
        w_accept = w_rd & bus.im_ready_i;
        // A response with nothing outstanding is a protocol error and ignored.
        w_resp   = bus.im_valid_i & (r_inflight != {IW{1'b0}});
        w_push   = w_resp & (r_drop == {IW{1'b0}}) & ~bus.x_bra_i;
        w_pop    = (r_count != {CW{1'b0}}) & (bus.f_kill_i | ~bus.f_stall_i) & ~bus.x_bra_i;
    end

    // Fetch PC and the shadow queue remembering the PC of each outstanding request.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc      <= RESET_PC;
            r_sh_wptr <= {SW{1'b0}};
            r_sh_rptr <= {SW{1'b0}};
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                r_sh_pc[i] <= 32'h0;
            end
        end else begin
            if (bus.x_bra_i) begin
                r_pc <= bus.x_pc_bra_i;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_accept) begin
                r_sh_pc[r_sh_wptr] <= r_pc;
                r_sh_wptr          <= sh_next(r_sh_wptr);
            end
            // Every counted response retires its shadow entry, stale or not.
            if (w_resp) begin
                r_sh_rptr <= sh_next(r_sh_rptr);
            end
        end
    end

    // Outstanding-request and pending-discard counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_inflight <= {IW{1'b0}};
            r_drop     <= {IW{1'b0}};
        end else begin
            case ({w_accept, w_resp})
                2'b10:   r_inflight <= r_inflight + IW'(1'b1);
                2'b01:   r_inflight <= r_inflight - IW'(1'b1);
                default: r_inflight <= r_inflight;
            endcase
            // On a branch everything still in flight after this cycle is stale.
            if (bus.x_bra_i) begin
                r_drop <= r_inflight - (w_resp ? IW'(1'b1) : IW'(1'b0));
            end else if (w_resp && (r_drop != {IW{1'b0}})) begin
                r_drop <= r_drop - IW'(1'b1);
            end
        end
    end

    // Instruction FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo_ir[i] <= 32'h0;
                r_fifo_pc[i] <= 32'h0;
            end
        end else if (bus.x_bra_i) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_fifo_ir[r_wptr] <= bus.im_data_i;
                r_fifo_pc[r_wptr] <= r_sh_pc[r_sh_rptr];
                r_wptr            <= r_wptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Request and FIFO-head outputs; head data reads registers only.
    always_comb begin
        bus.im_rd_o   = w_rd;
        bus.im_addr_o = r_pc;
        bus.f_valid_o = (r_count != {CW{1'b0}});
        if (r_count != {CW{1'b0}}) begin
            bus.f_ir_o        = r_fifo_ir[r_rptr];
            bus.f_pc_o        = r_fifo_pc[r_rptr];
            bus.f_pc_plus_4_o = r_fifo_pc[r_rptr] + 32'd4;
        end else begin
            bus.f_ir_o        = 32'h0;
            bus.f_pc_o        = 32'h0;
            bus.f_pc_plus_4_o = 32'h0;
        end
    end
endmodule
